// File: rtl/stepper_step_gen.sv
// Trapezoidal step-pulse generator: accepts move commands and emits
// single-cycle step pulses that accelerate, cruise and decelerate.
//
// state  | meaning
// IDLE   | no move in progress, ready for a command
// ACCEL  | period shrinking toward PERIOD_MIN after each step
// CRUISE | period held at PERIOD_MIN
// DECEL  | period growing back toward PERIOD_START
module stepper_step_gen #(
  parameter int STEP_W       = 16,
  parameter int CNT_W        = 24,
  parameter int PERIOD_START = 50000,
  parameter int PERIOD_MIN   = 5000,
  parameter int RAMP_DEC     = 500
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_dir,
  input  logic [STEP_W-1:0] cmd_steps,
  input  logic              abort,
  output logic              step,
  output logic              dir,
  output logic              busy,
  output logic              done,
  output logic [STEP_W-1:0] steps_left
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCEL,
    ST_CRUISE,
    ST_DECEL
  } state_t;

  localparam logic [CNT_W:0] P_START = (CNT_W+1)'(PERIOD_START);
  localparam logic [CNT_W:0] P_MIN   = (CNT_W+1)'(PERIOD_MIN);
  localparam logic [CNT_W:0] P_DEC   = (CNT_W+1)'(RAMP_DEC);

  state_t              state_q;
  logic [CNT_W-1:0]    period_q;
  logic [CNT_W-1:0]    timer_q;
  logic [STEP_W-1:0]   ramp_q;
  logic [STEP_W-1:0]   steps_left_q;
  logic                step_q;
  logic                dir_q;
  logic                busy_q;
  logic                done_q;
  logic                ready_q;

  logic [STEP_W-1:0]   rem_d;
  logic [CNT_W:0]      period_up_d;
  logic [CNT_W-1:0]    period_dn_d;
  state_t              state_d;
  logic [CNT_W-1:0]    period_d;
  logic [STEP_W-1:0]   ramp_d;

  // Profile decision taken at each step pulse, evaluated on the remaining count.
  always_comb begin
    rem_d       = steps_left_q - STEP_W'(1);
    period_up_d = {1'b0, period_q} + P_DEC;
    period_dn_d = period_q - P_DEC[CNT_W-1:0];
    state_d     = state_q;
    period_d    = period_q;
    ramp_d      = ramp_q;
    if (rem_d == '0) begin
      state_d = ST_IDLE;
    end else if (rem_d <= ramp_q) begin
      state_d  = ST_DECEL;
      period_d = (period_up_d > P_START) ? P_START[CNT_W-1:0] : period_up_d[CNT_W-1:0];
      ramp_d   = (ramp_q == '0) ? '0 : ramp_q - STEP_W'(1);
    end else if ({1'b0, period_q} > P_MIN) begin
      state_d  = ST_ACCEL;
      period_d = ({1'b0, period_q} >= P_MIN + P_DEC) ? period_dn_d : P_MIN[CNT_W-1:0];
      ramp_d   = ramp_q + STEP_W'(1);
    end else begin
      state_d = ST_CRUISE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      period_q     <= P_START[CNT_W-1:0];
      timer_q      <= '0;
      ramp_q       <= '0;
      steps_left_q <= '0;
      step_q       <= 1'b0;
      dir_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      ready_q      <= 1'b1;
    end else begin
      step_q <= 1'b0;
      done_q <= 1'b0;
      if (state_q == ST_IDLE) begin
        if (cmd_valid && ready_q) begin
          dir_q        <= cmd_dir;
          steps_left_q <= cmd_steps;
          period_q     <= P_START[CNT_W-1:0];
          ramp_q       <= '0;
          if (cmd_steps == '0) begin
            done_q <= 1'b1;
          end else begin
            state_q <= ST_ACCEL;
            step_q  <= 1'b1;
            busy_q  <= 1'b1;
            ready_q <= 1'b0;
          end
        end
      end else if (abort) begin
        // A pulse already on the wire still counts as issued.
        if (step_q) steps_left_q <= rem_d;
        state_q <= ST_IDLE;
        busy_q  <= 1'b0;
        ready_q <= 1'b1;
        done_q  <= 1'b1;
      end else if (step_q) begin
        steps_left_q <= rem_d;
        state_q      <= state_d;
        period_q     <= period_d;
        ramp_q       <= ramp_d;
        // Terminal count at zero: the next pulse lands period_d cycles later.
        timer_q      <= period_d - CNT_W'(2);
        if (rem_d == '0) begin
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
          done_q  <= 1'b1;
        end
      end else if (timer_q == '0) begin
        step_q <= 1'b1;
      end else begin
        timer_q <= timer_q - CNT_W'(1);
      end
    end
  end

  assign cmd_ready  = ready_q;
  assign step       = step_q;
  assign dir        = dir_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign steps_left = steps_left_q;

endmodule

// File: tb/tb_stepper_step_gen.sv
// Bench for stepper_step_gen: directed profile scenarios plus randomized
// moves, checked cycle by cycle against a step-time schedule model.
module tb_stepper_step_gen;

  localparam int STEP_W = 16;
  localparam int CNT_W  = 24;
  localparam int PS     = 10;
  localparam int PM     = 6;
  localparam int RD     = 2;

  logic              clk;
  logic              rst_n;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_dir;
  logic [STEP_W-1:0] cmd_steps;
  logic              abort;
  logic              step;
  logic              dir;
  logic              busy;
  logic              done;
  logic [STEP_W-1:0] steps_left;

  stepper_step_gen #(
    .STEP_W(STEP_W), .CNT_W(CNT_W), .PERIOD_START(PS), .PERIOD_MIN(PM), .RAMP_DEC(RD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dir(cmd_dir), .cmd_steps(cmd_steps), .abort(abort), .step(step),
    .dir(dir), .busy(busy), .done(done), .steps_left(steps_left)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int sched[$];
  int obs[$];
  int done_at;
  bit cur_dir;
  int cur_left;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic logic [31:0] pack(input bit s, input bit b, input bit dn, input bit r,
                                       input bit d, input int left);
    return {11'd0, s, b, dn, r, d, 16'(left)};
  endfunction

  function automatic logic [31:0] outs();
    return {11'd0, step, busy, done, cmd_ready, dir, steps_left};
  endfunction

  // Step times relative to the accept cycle, straight from the profile rules.
  task automatic build_sched(input int n);
    int period, ramp, r, t;
    sched.delete();
    period = PS; ramp = 0; r = n; t = 1;
    while (r > 0) begin
      sched.push_back(t);
      r--;
      if (r == 0) break;
      if (r <= ramp) begin
        period = (period + RD > PS) ? PS : period + RD;
        ramp   = (ramp > 0) ? ramp - 1 : 0;
      end else if (period > PM) begin
        period = (period - RD < PM) ? PM : period - RD;
        ramp++;
      end
      t += period;
    end
  endtask

  function automatic int cnt_before(input int k);
    int c = 0;
    foreach (sched[i]) if (sched[i] < k) c++;
    return c;
  endfunction

  function automatic bit in_sched(input int k);
    foreach (sched[i]) if (sched[i] == k) return 1'b1;
    return 1'b0;
  endfunction

  // Entered at the negedge of the accept cycle; leaves at the negedge of the
  // done cycle with that cycle's inputs already driven (chain = next command).
  task automatic move(input bit d, input int n, input int ab, input int rs,
                      input bit chain, input bit cd, input int cn);
    int last, fin;
    build_sched(n);
    last = (sched.size() > 0) ? sched[sched.size()-1] : 0;
    fin  = last + 1;
    if (ab > 0 && ab < fin) fin = ab + 1;
    obs.delete();
    done_at   = -1;
    cmd_valid = 1'b1; cmd_dir = d; cmd_steps = STEP_W'(n); abort = 1'b0;
    for (int k = 1; k <= fin; k++) begin
      @(negedge clk);
      if (step) obs.push_back(k);
      if (done && done_at < 0) done_at = k;
      if (k < fin) chk($sformatf("move_c%0d", k), outs(), pack(in_sched(k), 1, 0, 0, d, n - cnt_before(k)));
      else         chk($sformatf("move_done_c%0d", k), outs(), pack(0, 0, 1, 1, d, n - cnt_before(k)));
      if (k == rs) begin
        cmd_valid = 1'b0; abort = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_async", outs(), pack(0, 0, 0, 1, 0, 0));
        repeat (3) begin
          @(negedge clk);
          chk("rst_hold", outs(), pack(0, 0, 0, 1, 0, 0));
        end
        rst_n = 1'b1;
        cur_dir = 1'b0; cur_left = 0;
        return;
      end
      abort = (k == ab);
      if (k < fin) begin
        cmd_valid = chain | 1'($urandom);
        cmd_steps = STEP_W'($urandom);
        cmd_dir   = 1'($urandom);
      end else begin
        cmd_valid = chain; cmd_dir = cd; cmd_steps = STEP_W'(cn);
      end
    end
    cur_dir  = d;
    cur_left = n - cnt_before(fin);
  endtask

  task automatic idle(input int c);
    cmd_valid = 1'b0;
    for (int i = 0; i < c; i++) begin
      abort     = 1'($urandom);
      cmd_steps = STEP_W'($urandom);
      cmd_dir   = 1'($urandom);
      @(negedge clk);
      chk("idle", outs(), pack(0, 0, 0, 1, cur_dir, cur_left));
    end
    abort = 1'b0;
  endtask

  task automatic chk_times(input string tag, input int exp_t[$]);
    chk({tag, "_count"}, 32'(obs.size()), 32'(exp_t.size()));
    foreach (exp_t[i]) chk($sformatf("%s_t%0d", tag, i), (i < obs.size()) ? 32'(obs[i]) : 32'hffff_ffff, 32'(exp_t[i]));
  endtask

  initial begin
    int full_t[$];
    int short_t[$];
    int one_t[$];
    bit d, nd, ch;
    int n, nn, ab;
    full_t  = '{1, 9, 15, 21, 27, 33, 39, 45, 53, 63};
    short_t = '{1, 9, 19};
    one_t   = '{1};

    rst_n = 1'b0; cmd_valid = 1'b1; cmd_dir = 1'b1; cmd_steps = 16'd5; abort = 1'b0;
    cur_dir = 1'b0; cur_left = 0;
    repeat (2) @(negedge clk);
    chk("reset", outs(), pack(0, 0, 0, 1, 0, 0));
    rst_n = 1'b1;
    idle(20);

    move(1, 10, 0, 0, 0, 0, 0);
    chk_times("full", full_t);
    chk("full_done_at", 32'(done_at), 32'd64);
    chk("full_left", 32'(steps_left), 32'd0);
    idle(5);

    move(0, 3, 0, 0, 0, 0, 0);
    chk_times("short", short_t);
    chk("short_done_at", 32'(done_at), 32'd20);
    idle(3);

    move(1, 0, 0, 0, 0, 0, 0);
    chk("zero_done_at", 32'(done_at), 32'd1);
    chk("zero_no_step", 32'(obs.size()), 32'd0);
    idle(3);

    move(1, 10, 14, 0, 1, 0, 1);
    chk("abort_done_at", 32'(done_at), 32'd15);
    chk("abort_left", 32'(steps_left), 32'd8);
    chk("abort_steps", 32'(obs.size()), 32'd2);
    move(0, 1, 0, 0, 0, 0, 0);
    chk_times("after_abort", one_t);
    idle(3);

    move(1, 6, 0, 0, 1, 1, 4);
    move(1, 4, 0, 0, 0, 0, 0);
    idle(3);

    move(1, 10, 0, 20, 0, 0, 0);
    idle(10);

    nd = 1'($urandom); nn = $urandom_range(0, 25);
    for (int i = 0; i < 25; i++) begin
      d = nd; n = nn;
      nd = 1'($urandom); nn = $urandom_range(0, 25);
      ch = 1'($urandom);
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 120) : 0;
      move(d, n, ab, 0, ch, nd, nn);
      if (!ch) idle($urandom_range(1, 4));
    end
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/stepper_step_gen.md
# stepper_step_gen

Motion-profile step generator sitting directly upstream of the four-phase stepper sequencer. Accepts move commands (direction + step count) over a valid/ready handshake. Emits single-cycle `step` pulses with a registered `dir` under a trapezoidal profile: accelerate from a start period to a minimum period, cruise, then decelerate symmetrically. The sequencer advances one phase per `step` pulse in the direction given by `dir`.

## Interface

Parameters:

- `STEP_W`, 16, width of step count
- `CNT_W`, 24, width of period timer; must hold `PERIOD_START`
- `PERIOD_START`, 50000, step spacing in clk cycles at rest/ramp ends
- `PERIOD_MIN`, 5000, cruise step spacing; must be ≥ 2 and ≤ `PERIOD_START`
- `RAMP_DEC`, 500, period change per step while ramping

Ports (one clock; reset is asynchronous and active-low):

- `clk` in 1: system clock
- `rst_n` in 1: async active-low reset
- `cmd_valid` in 1: command present
- `cmd_ready` out 1: block can accept a command; high only in IDLE
- `cmd_dir` in 1: direction of the command
- `cmd_steps` in STEP_W: number of steps to issue
- `abort` in 1: stop the move immediately
- `step` out 1: one-cycle step pulse to the sequencer
- `dir` out 1: direction, stable for the whole move
- `busy` out 1: a move is in progress
- `done` out 1: one-cycle pulse at the end of a move
- `steps_left` out STEP_W: steps still to be issued

## Operation

- States: IDLE, ACCEL, CRUISE, DECEL.
- Accept: the command is taken when `cmd_valid && cmd_ready`. On accept:
  - `dir` ← `cmd_dir`, `steps_left` ← `cmd_steps`.
  - period ← `PERIOD_START`, ramp_cnt ← 0.
- Zero-step command (`cmd_steps`=0): accepted; no step is issued; `done` pulses the next cycle; state stays IDLE.
- Nonzero command: state goes to ACCEL.
- Step event: on each `step` pulse, r = `steps_left` − 1 is written to `steps_left`. Next state and period are then chosen in this priority order:
  1. r = 0: go to IDLE.
  2. r ≤ ramp_cnt: go to DECEL; period ← min(period + `RAMP_DEC`, `PERIOD_START`); ramp_cnt ← ramp_cnt − 1, saturating at 0.
  3. period > `PERIOD_MIN`: go to ACCEL; period ← max(period − `RAMP_DEC`, `PERIOD_MIN`); ramp_cnt ← ramp_cnt + 1.
  4. Otherwise: go to CRUISE; period is unchanged.
- Spacing: the gap from one step to the next equals the period value updated at the earlier step.
- Arithmetic: period arithmetic is CNT_W-bit and saturating; it never wraps. ramp_cnt is STEP_W bits.
- Abort:
  - While busy, `abort`=1 moves the block to IDLE on the next edge, and `done` pulses.
  - If abort coincides with a step-due cycle, abort wins: no step is issued.
  - `steps_left` holds its value until the next accept.
  - Abort in IDLE is ignored.
- `dir` changes only on accept.

## Timing

- Reset values: `cmd_ready`=1, `step`=0, `dir`=0, `busy`=0, `done`=0, `steps_left`=0. State is IDLE.
- Reset mid-move: all outputs return to their reset values asynchronously. No further step is issued.
- Accept at edge T0 (nonzero command): `busy`=1 and `cmd_ready`=0 from T0+1. The first `step` is at T0+1.
- Completion: the last `step` is at cycle Tn. `done`=1, `busy`=0 and `cmd_ready`=1 at Tn+1.
- Back-to-back moves: a new command may be accepted in the `done` cycle. Its first step follows one cycle later.
- All outputs are registered. `step` is never high on two consecutive cycles.

## Test plan

Unless noted, scenarios use `PERIOD_START`=10, `PERIOD_MIN`=6, `RAMP_DEC`=2.

- Reset then idle: hold `rst_n`=0 → all outputs at reset values. Release reset with no command → no `step` ever.
- Full profile: accept `cmd_steps`=10, `cmd_dir`=1 at T0.
  - Steps at T1, 9, 15, 21, 27, 33, 39, 45, 53, 63 (gaps 8, 6, 6, 6, 6, 6, 6, 8, 10).
  - `done` at T64; `dir`=1 throughout; `steps_left` reads 0 at T64.
- Short move with no cruise: `cmd_steps`=3 at T0 → steps at T1, 9, 19; `done` at T20.
- Zero steps: `cmd_steps`=0 → `done` one cycle after accept; no `step`; `busy` never goes high.
- Abort: 10-step move, `abort` pulsed at T14 → no step at T15 or later; `done` at T15; `steps_left`=8 holds.
  - Then accept `cmd_steps`=1, `cmd_dir`=0 in the `done` cycle → one step, with `dir`=0.
- Handshake under load: hold `cmd_valid`=1 with changing `cmd_steps` during a move → `cmd_ready` stays 0 and nothing is accepted. The pending command is accepted in the `done` cycle.
